// File: rtl/mezcla_bandas_pkg.sv
// Shared fixed-point format, saturation limits and FSM encoding for the
// three-band mixer.
package mezcla_bandas_pkg;

  localparam int SIGN = 1;
  localparam int PF   = 14;
  localparam int MAG  = 7;
  localparam int SIZE = SIGN + PF + MAG;

  localparam logic signed [SIZE-1:0] SAT_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic signed [SIZE-1:0] SAT_MIN = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC1 = 3'd1,
    MAC2 = 3'd2,
    MAC3 = 3'd3,
    OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/mezcla_bandas_mult.sv
// Signed fixed-point multiplier: full-width product followed by an
// arithmetic right shift, so the fraction is floored toward minus infinity.
module mult_punto_fijo
  import mezcla_bandas_pkg::*;
#(
  parameter int size = SIZE,
  parameter int pf   = PF
) (
  input  logic signed [size-1:0]   a_i,
  input  logic signed [size-1:0]   b_i,
  output logic signed [2*size-1:0] p_o
);

  localparam int PW = 2 * size;

  logic signed [PW-1:0] mulFull;

  assign mulFull = PW'(a_i) * PW'(b_i);
  assign p_o     = mulFull >>> pf;

endmodule

// File: rtl/mezcla_bandas.sv
// Three-band weighted mixer: latches samples and gains on EN, accumulates
// the three products over three cycles through one shared multiplier and
// presents the saturated sum with a single-cycle valid pulse.
module mezcla_bandas
  import mezcla_bandas_pkg::*;
#(
  parameter int sign = SIGN,
  parameter int pf   = PF,
  parameter int mag  = MAG,
  parameter int size = sign + pf + mag
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EN,
  input  logic signed [size-1:0] y1,
  input  logic signed [size-1:0] y2,
  input  logic signed [size-1:0] y3,
  input  logic signed [size-1:0] g1,
  input  logic signed [size-1:0] g2,
  input  logic signed [size-1:0] g3,
  output logic signed [size-1:0] y,
  output logic                   valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int AW = size + 2;
  localparam int PW = 2 * size;
  localparam int SW = PW + 1;

  localparam logic signed [size-1:0] SatMax =
    (size == SIZE) ? size'(SAT_MAX) : size'({1'b0, {(size-1){1'b1}}});
  localparam logic signed [size-1:0] SatMin =
    (size == SIZE) ? size'(SAT_MIN) : size'({1'b1, {(size-1){1'b0}}});

  localparam logic signed [AW-1:0] AccHi  = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AccLo  = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [SW-1:0] AccHiW = SW'(AccHi);
  localparam logic signed [SW-1:0] AccLoW = SW'(AccLo);
  localparam logic signed [AW-1:0] YHiA   = AW'(SatMax);
  localparam logic signed [AW-1:0] YLoA   = AW'(SatMin);

  state_t state_q;

  logic signed [size-1:0] y1_q, y2_q, y3_q;
  logic signed [size-1:0] g1_q, g2_q, g3_q;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [size-1:0] y_q, ySat;
  logic                   valid_q, busy_q, overrun_q;

  logic signed [size-1:0] mulA, mulB;
  logic signed [PW-1:0]   mulP;
  logic signed [SW-1:0]   sumWide;

  // Each MAC state steers its own band into the single multiplier.
  always_comb begin
    mulA = '0;
    mulB = '0;
    case (state_q)
      MAC1: begin mulA = y1_q; mulB = g1_q; end
      MAC2: begin mulA = y2_q; mulB = g2_q; end
      MAC3: begin mulA = y3_q; mulB = g3_q; end
      default: ;
    endcase
  end

  mult_punto_fijo #(
    .size(size),
    .pf  (pf)
  ) uMult (
    .a_i(mulA),
    .b_i(mulB),
    .p_o(mulP)
  );

  // The add is done one bit wider than the product and then clamped, so
  // the accumulator can never wrap even with extreme gains.
  always_comb begin
    sumWide = SW'(acc_q) + SW'(mulP);
    if (sumWide > AccHiW)      acc_d = AccHi;
    else if (sumWide < AccLoW) acc_d = AccLo;
    else                       acc_d = sumWide[AW-1:0];

    if (acc_d > YHiA)      ySat = SatMax;
    else if (acc_d < YLoA) ySat = SatMin;
    else                   ySat = acc_d[size-1:0];
  end

  // y and valid are loaded on the MAC3->OUT transition so they are visible
  // for exactly the OUT cycle; busy tracks every non-IDLE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      y1_q      <= '0;
      y2_q      <= '0;
      y3_q      <= '0;
      g1_q      <= '0;
      g2_q      <= '0;
      g3_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (EN && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (EN) begin
            y1_q    <= y1;
            y2_q    <= y2;
            y3_q    <= y3;
            g1_q    <= g1;
            g2_q    <= g2;
            g3_q    <= g3;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC1;
          end
        end
        MAC1: begin
          acc_q   <= acc_d;
          state_q <= MAC2;
        end
        MAC2: begin
          acc_q   <= acc_d;
          state_q <= MAC3;
        end
        MAC3: begin
          acc_q   <= acc_d;
          y_q     <= ySat;
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: doc/mezcla_bandas.md
MEZCLA_BANDAS -- requirements
Module: mezcla_bandas

Interface
REQ-001 The block SHALL have parameter sign, default 1, sign bits of the fixed-point format.
REQ-002 The block SHALL have parameter pf, default 14, fractional bits.
REQ-003 The block SHALL have parameter mag, default 7, integer magnitude bits.
REQ-004 The block SHALL have parameter size, default sign+pf+mag (22), total word width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; every register is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 The block SHALL have port EN, input, 1, a one-cycle sample strobe that starts a mix.
REQ-008 The block SHALL have ports y1, y2, y3, input, signed size, the low, mid and high band samples.
REQ-009 The block SHALL have ports g1, g2, g3, input, signed size, per-band gains in the same Q format.
REQ-010 The block SHALL have port y, output, signed size, the registered mixed sample.
REQ-011 The block SHALL have port valid, output, 1, a one-cycle pulse marking a new y.
REQ-012 The block SHALL have port busy, output, 1, high while a mix is in progress.
REQ-013 The block SHALL have port overrun, output, 1, sticky; set when an EN arrives during a mix.

Function
REQ-014 The block SHALL use the FSM states IDLE, MAC1, MAC2, MAC3 and OUT.
REQ-015 In IDLE, EN=1 SHALL latch y1..y3 and g1..g3, clear the accumulator and move the FSM to MAC1.
REQ-016 MAC1, MAC2 and MAC3 SHALL each add (latched yk * latched gk) >>> pf to the accumulator, for k=1, 2, 3 in that order, using one shared multiplier.
REQ-017 The product SHALL be 2*size bits wide, and the shift SHALL be arithmetic, truncating toward minus infinity.
REQ-018 The accumulator SHALL be size+2 bits wide and SHALL NOT overflow internally.
REQ-019 OUT SHALL load y with the accumulator saturated to the range [0x200000, 0x1FFFFF] (size=22), assert valid for that single cycle and return to IDLE.
REQ-020 Latency SHALL be EN accepted at cycle 0, then y updated and valid=1 at cycle 4; the next EN is accepted at cycle 5 at the earliest.
REQ-021 busy SHALL be 1 in MAC1 through OUT and 0 in IDLE.
REQ-022 EN in any state other than IDLE SHALL be ignored, SHALL NOT disturb the latched operands, and SHALL set overrun.
REQ-023 overrun SHALL clear only on rst.
REQ-024 y SHALL hold its value between valid pulses.
REQ-025 Input changes after the EN cycle SHALL NOT affect the result.

Reset
REQ-026 With rst=1 at a clock edge, the block SHALL set the state to IDLE and clear y, valid, busy, overrun, the accumulator and all operand latches to 0.
REQ-027 rst SHALL take priority over EN.
REQ-028 A mix interrupted by rst SHALL be discarded with no valid pulse.

Structure
REQ-029 A shared package SHALL hold the default sign/pf/mag/size values, the SAT_MAX/SAT_MIN constants and the FSM state encoding.
REQ-030 The block SHALL contain one sub-module, mult_punto_fijo: a signed size x size multiply with >>> pf, instantiated once and shared by the three MAC states.

Verification
REQ-031 The bench SHALL drive y1=y2=y3=0x004000, g1=g2=g3=0x004000 and EN at cycle 0, and SHALL require y=0x00C000 and valid=1 exactly at cycle 4, with busy high over cycles 1-4.
REQ-032 The bench SHALL drive y1=y2=y3=0x1FFFFF with gains 0x004000, then y1=y2=y3=0x200000 with the same gains, and SHALL require y=0x1FFFFF and then y=0x200000 (saturation).
REQ-033 The bench SHALL drive y1=0x000001 with g1=0x002000 and the other gains 0, then y1=0x3FFFFF with the same gains, and SHALL require y=0x000000 and then y=0x3FFFFF (floor truncation).
REQ-034 The bench SHALL drive y1=y3=0x008000, g1=0x004000, g2=0, g3=0x3FC000, and SHALL require y=0x000000.
REQ-035 The bench SHALL pulse EN again at cycle 2 of a mix, and SHALL require the original result, a single valid pulse and overrun=1 until rst.
REQ-036 The bench SHALL assert rst at cycle 2 of a mix, and SHALL require y=0, valid=0, busy=0, no valid pulse afterwards, and a following EN to produce a correct result 4 cycles later.
